// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: time-multiplexed seven-segment display controller.
// A prescaler divides the clock into digit slots; each slot starts with a few
// blanked cycles to avoid ghosting, then lights one digit decoded by a single
// shared hex decoder. New values are double-buffered and only swapped in at
// the end of a frame, so the display never tears.

// Hex nibble to active-low seven-segment pattern, ordered {g,f,e,d,c,b,a}.
module hex2seven_seg (
    input  logic [3:0] hex,
    output logic [6:0] seg_n
);

    // Pure lookup of the glyph for one hex digit.
    always_comb begin
        seg_n = 7'h7F;
        case (hex)
            4'h0:    seg_n = 7'b1000000;
            4'h1:    seg_n = 7'b1111001;
            4'h2:    seg_n = 7'b0100100;
            4'h3:    seg_n = 7'b0110000;
            4'h4:    seg_n = 7'b0011001;
            4'h5:    seg_n = 7'b0010010;
            4'h6:    seg_n = 7'b0000010;
            4'h7:    seg_n = 7'b1111000;
            4'h8:    seg_n = 7'b0000000;
            4'h9:    seg_n = 7'b0010000;
            4'hA:    seg_n = 7'b0001000;
            4'hB:    seg_n = 7'b0000011;
            4'hC:    seg_n = 7'b1000110;
            4'hD:    seg_n = 7'b0100001;
            4'hE:    seg_n = 7'b0000110;
            4'hF:    seg_n = 7'b0001110;
            default: seg_n = 7'h7F;
        endcase
    end

endmodule

module seven_seg_scanner #(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 50000,
    parameter int BLANK    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  load,
    input  logic                  lzs_en,
    input  logic [DIGITS-1:0]     dp_mask,
    output logic [6:0]            seg_n,
    output logic                  dp_n,
    output logic [DIGITS-1:0]     an_n,
    output logic                  pending,
    output logic                  frame_done
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [CNT_W-1:0]    cnt_r;
    logic [IDX_W-1:0]    idx_r;
    logic [4*DIGITS-1:0] hold_r;
    logic [4*DIGITS-1:0] disp_r;
    logic                pending_r;
    logic [6:0]          seg_r;
    logic                dp_r;
    logic [DIGITS-1:0]   an_r;
    logic                frame_done_r;

    logic                slot_end_s;
    logic                last_digit_s;
    logic                boundary_s;
    logic                blank_s;
    logic [3:0]          nibble_s;
    logic [6:0]          dec_seg_s;
    logic [DIGITS-1:0]   upper_zero_s;
    logic                zero_run_s;
    logic                suppress_s;
    logic [6:0]          seg_nxt_s;
    logic [DIGITS-1:0]   an_nxt_s;

    // Slot/frame position decode and current digit selection.
    always_comb begin
        slot_end_s   = (cnt_r == CNT_W'(TICK_DIV - 1));
        last_digit_s = (idx_r == IDX_W'(DIGITS - 1));
        boundary_s   = slot_end_s && last_digit_s;
        blank_s      = (cnt_r < CNT_W'(BLANK));
        nibble_s     = disp_r[{idx_r, 2'b00} +: 4];
    end

    // upper_zero_s[i] is set when nibbles i..DIGITS-1 of the shown value are all zero.
    always_comb begin
        upper_zero_s = '0;
        zero_run_s   = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run_s      = zero_run_s && (disp_r[4*i +: 4] == 4'h0);
            upper_zero_s[i] = zero_run_s;
        end
    end

    // Digit 0 always shows, so a zero value still displays a single "0".
    always_comb begin
        if (lzs_en && (idx_r != '0)) begin
            suppress_s = upper_zero_s[idx_r];
        end else begin
            suppress_s = 1'b0;
        end
    end

    hex2seven_seg u_dec (
        .hex   (nibble_s),
        .seg_n (dec_seg_s)
    );

    // Next-state values for the segment and digit-enable pins.
    always_comb begin
        seg_nxt_s = 7'h7F;
        an_nxt_s  = '1;
        if (blank_s || suppress_s) begin
            seg_nxt_s = 7'h7F;
        end else begin
            seg_nxt_s = dec_seg_s;
        end
        for (int i = 0; i < DIGITS; i++) begin
            an_nxt_s[i] = blank_s || (idx_r != IDX_W'(i));
        end
    end

    // Prescaler and slot index: one slot per TICK_DIV cycles, wrapping per frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= '0;
            idx_r <= '0;
        end else if (slot_end_s) begin
            cnt_r <= '0;
            if (last_digit_s) begin
                idx_r <= '0;
            end else begin
                idx_r <= idx_r + IDX_W'(1);
            end
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    // Double buffer: loads land in hold_r, and are promoted to disp_r only at the frame boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_r    <= '0;
            disp_r    <= '0;
            pending_r <= 1'b0;
        end else begin
            if (boundary_s && pending_r) begin
                disp_r <= hold_r;
            end
            if (load) begin
                hold_r    <= value;
                pending_r <= 1'b1;
            end else if (boundary_s) begin
                pending_r <= 1'b0;
            end
        end
    end

    // Registered pin drivers so the board sees glitch-free outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_r        <= 7'h7F;
            dp_r         <= 1'b1;
            an_r         <= '1;
            frame_done_r <= 1'b0;
        end else begin
            seg_r        <= seg_nxt_s;
            dp_r         <= ~dp_mask[idx_r];
            an_r         <= an_nxt_s;
            frame_done_r <= boundary_s;
        end
    end

    assign seg_n      = seg_r;
    assign dp_n       = dp_r;
    assign an_n       = an_r;
    assign pending    = pending_r;
    assign frame_done = frame_done_r;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench for seven_seg_scanner with a short slot length.
// Expected per-digit glyphs are queued when a value is loaded and popped
// when the frame showing that value is scanned out.
module tb_seven_seg_scanner;

    localparam int DIGITS   = 4;
    localparam int TICK_DIV = 8;
    localparam int BLANK    = 2;
    localparam int FRAME    = DIGITS * TICK_DIV;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value;
    logic        load;
    logic        lzs_en;
    logic [3:0]  dp_mask;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [3:0]  an_n;
    logic        pending;
    logic        frame_done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [6:0] exp_q[$];

    seven_seg_scanner #(
        .DIGITS   (DIGITS),
        .TICK_DIV (TICK_DIV),
        .BLANK    (BLANK)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .value      (value),
        .load       (load),
        .lzs_en     (lzs_en),
        .dp_mask    (dp_mask),
        .seg_n      (seg_n),
        .dp_n       (dp_n),
        .an_n       (an_n),
        .pending    (pending),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish at cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [6:0] dec(input logic [3:0] h);
        case (h)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            4'hF: return 7'b0001110;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [6:0] exp_digit(input logic [15:0] v, input int d, input logic lzs);
        logic [15:0] upper;
        upper = v >> (4 * d);
        if (lzs && (d != 0) && (upper == 16'h0000)) return 7'h7F;
        return dec(upper[3:0]);
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic to_frame_start();
        for (int i = 0; i < FRAME && (cyc % FRAME) != 0; i++) tick();
    endtask

    task automatic push_value(input logic [15:0] v);
        for (int d = 0; d < DIGITS; d++) exp_q.push_back(exp_digit(v, d, lzs_en));
    endtask

    task automatic load_value(input logic [15:0] v);
        value = v;
        load  = 1'b1;
        tick();
        load  = 1'b0;
        checks++;
        if (pending !== 1'b1) begin
            errors++;
            $display("FAIL pending_rise cyc=%0d actual=%b expected=1", cyc, pending);
        end
    endtask

    // Scan one whole frame starting at a frame boundary and compare every cycle.
    task automatic check_frame(input string tag);
        logic [6:0] exp_seg [DIGITS];
        logic [3:0] one_hot;
        logic [3:0] exp_an;
        logic [6:0] exp_s;
        logic       exp_dp;
        logic       exp_fd;
        for (int d = 0; d < DIGITS; d++) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s scoreboard empty for digit %0d", tag, d);
                exp_seg[d] = 7'h7F;
            end else begin
                exp_seg[d] = exp_q.pop_front();
            end
        end
        for (int d = 0; d < DIGITS; d++) begin
            for (int k = 1; k <= TICK_DIV; k++) begin
                tick();
                one_hot = 4'b0001;
                exp_an  = (k <= BLANK) ? 4'hF : ~(one_hot << d);
                exp_s   = (k <= BLANK) ? 7'h7F : exp_seg[d];
                exp_dp  = ~dp_mask[d];
                exp_fd  = ((cyc % FRAME) == 0);
                checks++;
                if (an_n !== exp_an) begin
                    errors++;
                    $display("FAIL %s an_n cyc=%0d digit=%0d actual=%h expected=%h", tag, cyc, d, an_n, exp_an);
                end
                checks++;
                if (seg_n !== exp_s) begin
                    errors++;
                    $display("FAIL %s seg_n cyc=%0d digit=%0d actual=%b expected=%b", tag, cyc, d, seg_n, exp_s);
                end
                checks++;
                if (dp_n !== exp_dp) begin
                    errors++;
                    $display("FAIL %s dp_n cyc=%0d digit=%0d actual=%b expected=%b", tag, cyc, d, dp_n, exp_dp);
                end
                checks++;
                if (frame_done !== exp_fd) begin
                    errors++;
                    $display("FAIL %s frame_done cyc=%0d actual=%b expected=%b", tag, cyc, frame_done, exp_fd);
                end
            end
        end
    endtask

    // Pulse reset and check the outputs from cycle 0 through the first two frames.
    task automatic check_restart(input string tag);
        logic [3:0] exp_an;
        logic       exp_fd;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cyc = 0;
        checks++;
        if (an_n !== 4'hF || seg_n !== 7'h7F || dp_n !== 1'b1) begin
            errors++;
            $display("FAIL %s reset_pins actual=%h/%h/%b expected=f/7f/1", tag, an_n, seg_n, dp_n);
        end
        checks++;
        if (pending !== 1'b0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL %s reset_flags actual=%b/%b expected=0/0", tag, pending, frame_done);
        end
        for (int i = 1; i <= 2 * FRAME; i++) begin
            tick();
            if (cyc <= TICK_DIV) begin
                exp_an = (cyc <= BLANK) ? 4'hF : 4'hE;
                checks++;
                if (an_n !== exp_an) begin
                    errors++;
                    $display("FAIL %s start_an_n cyc=%0d actual=%h expected=%h", tag, cyc, an_n, exp_an);
                end
                if (cyc <= BLANK) begin
                    checks++;
                    if (seg_n !== 7'h7F) begin
                        errors++;
                        $display("FAIL %s start_seg_n cyc=%0d actual=%h expected=7f", tag, cyc, seg_n);
                    end
                end
            end
            exp_fd = ((cyc % FRAME) == 0);
            checks++;
            if (frame_done !== exp_fd) begin
                errors++;
                $display("FAIL %s start_frame_done cyc=%0d actual=%b expected=%b", tag, cyc, frame_done, exp_fd);
            end
        end
    endtask

    task automatic test_reset();
        check_restart("reset");
    endtask

    task automatic test_load_basic();
        tick_n(10);
        exp_q.push_back(7'b0011001);
        exp_q.push_back(7'b0110000);
        exp_q.push_back(7'b0100100);
        exp_q.push_back(7'b1111001);
        load_value(16'h1234);
        for (int i = 0; i < FRAME && (cyc % FRAME) != FRAME - 1; i++) tick();
        checks++;
        if (pending !== 1'b1) begin
            errors++;
            $display("FAIL load_pending_hold cyc=%0d actual=%b expected=1", cyc, pending);
        end
        tick();
        checks++;
        if (pending !== 1'b0) begin
            errors++;
            $display("FAIL load_pending_fall cyc=%0d actual=%b expected=0", cyc, pending);
        end
        check_frame("load_1234");
    endtask

    task automatic test_lzs();
        lzs_en = 1'b1;
        tick_n(5);
        exp_q.push_back(7'b1000000);
        exp_q.push_back(7'b0010010);
        exp_q.push_back(7'h7F);
        exp_q.push_back(7'h7F);
        load_value(16'h0050);
        to_frame_start();
        check_frame("lzs_0050");
        tick_n(5);
        exp_q.push_back(7'b1000000);
        exp_q.push_back(7'h7F);
        exp_q.push_back(7'h7F);
        exp_q.push_back(7'h7F);
        load_value(16'h0000);
        to_frame_start();
        check_frame("lzs_0000");
    endtask

    task automatic test_back_to_back();
        lzs_en = 1'b0;
        tick_n(12);
        push_value(16'hAAAA);
        load_value(16'hAAAA);
        for (int i = 0; i < FRAME && (cyc % FRAME) != FRAME - 1; i++) tick();
        push_value(16'h5555);
        value = 16'h5555;
        load  = 1'b1;
        tick();
        load  = 1'b0;
        checks++;
        if (pending !== 1'b1) begin
            errors++;
            $display("FAIL b2b_pending_kept cyc=%0d actual=%b expected=1", cyc, pending);
        end
        check_frame("b2b_first");
        checks++;
        if (pending !== 1'b0) begin
            errors++;
            $display("FAIL b2b_pending_clear cyc=%0d actual=%b expected=0", cyc, pending);
        end
        check_frame("b2b_second");
    endtask

    task automatic test_dp();
        dp_mask = 4'b0100;
        lzs_en  = 1'b1;
        tick_n(3);
        exp_q.push_back(7'b1000000);
        exp_q.push_back(7'b0110000);
        exp_q.push_back(7'h7F);
        exp_q.push_back(7'h7F);
        load_value(16'h0030);
        to_frame_start();
        check_frame("dp_slot2");
    endtask

    task automatic test_reset_mid();
        dp_mask = 4'b0000;
        lzs_en  = 1'b0;
        tick_n(11);
        load_value(16'h1234);
        tick_n(2);
        check_restart("reset_mid");
        push_value(16'h0000);
        check_frame("reset_mid_disp");
        checks++;
        if (pending !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_pending cyc=%0d actual=%b expected=0", cyc, pending);
        end
    endtask

    initial begin
        rst     = 1'b1;
        value   = 16'h0000;
        load    = 1'b0;
        lzs_en  = 1'b0;
        dp_mask = 4'b0000;
        tick_n(2);
        test_reset();
        test_load_basic();
        test_lzs();
        test_back_to_back();
        test_dp();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
